// File: rtl/hpu_vram_port.sv
// VRAM arbiter: a single-port byte array shared between the tile fetcher and a
// queued CPU port that only gets memory slots during the blanking window.
module hpu_vram_port #(
  parameter int MEM_BYTES   = 16384,
  parameter int FIFO_DEPTH  = 4,
  parameter int BLANK_FIRST = 480,
  parameter int BLANK_LAST  = 519
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  true_line,
  input  logic [15:0] vid_addr,
  output logic [7:0]  vid_data,
  input  logic        cpu_valid,
  output logic        cpu_ready,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_rvalid,
  output logic [7:0]  cpu_rdata
);

  localparam int          AW        = $clog2(MEM_BYTES);
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam logic [16:0] MEM_LIMIT = 17'(MEM_BYTES);
  localparam logic [9:0]  WIN_FIRST = 10'(BLANK_FIRST);
  localparam logic [9:0]  WIN_LAST  = 10'(BLANK_LAST);
  localparam logic [PW:0] FIFO_FULL = (PW+1)'(FIFO_DEPTH);

  logic [7:0]    r_mem     [MEM_BYTES];
  logic          r_q_we    [FIFO_DEPTH];
  logic [15:0]   r_q_addr  [FIFO_DEPTH];
  logic [7:0]    r_q_wdata [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;
  logic          r_ready;
  logic [7:0]    r_vid_data;
  logic          r_rvalid;
  logic [7:0]    r_rdata;

  logic          w_window;
  logic          w_push;
  logic          w_pop;
  logic          w_head_we;
  logic [15:0]   w_head_addr;
  logic [7:0]    w_head_wdata;
  logic          w_head_ok;
  logic          w_vid_ok;
  logic [PW:0]   w_count_next;

  // Slot arbitration, queue head decode and next occupancy.
  always_comb begin
    w_window     = (true_line >= WIN_FIRST) && (true_line <= WIN_LAST);
    w_push       = cpu_valid && r_ready && !reset;
    w_pop        = w_window && (r_count != {(PW+1){1'b0}}) && !reset;
    w_head_we    = r_q_we[r_rptr];
    w_head_addr  = r_q_addr[r_rptr];
    w_head_wdata = r_q_wdata[r_rptr];
    w_head_ok    = {1'b0, w_head_addr} < MEM_LIMIT;
    w_vid_ok     = {1'b0, vid_addr} < MEM_LIMIT;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + {{PW{1'b0}}, 1'b1};
      2'b01:   w_count_next = r_count - {{PW{1'b0}}, 1'b1};
      default: w_count_next = r_count;
    endcase
  end

  // Storage has no reset so VRAM contents survive it; out-of-range writes drop here.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_we[r_wptr]    <= cpu_we;
      r_q_addr[r_wptr]  <= cpu_addr;
      r_q_wdata[r_wptr] <= cpu_wdata;
    end
    if (w_pop && w_head_we && w_head_ok) begin
      r_mem[w_head_addr[AW-1:0]] <= w_head_wdata;
    end
  end

  // Queue pointers, registered ready and the single read port's output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= {PW{1'b0}};
      r_rptr     <= {PW{1'b0}};
      r_count    <= {(PW+1){1'b0}};
      r_ready    <= 1'b1;
      r_vid_data <= 8'h00;
      r_rvalid   <= 1'b0;
      r_rdata    <= 8'h00;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + {{(PW-1){1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rptr <= r_rptr + {{(PW-1){1'b0}}, 1'b1};
      end
      r_count <= w_count_next;
      r_ready <= (w_count_next != FIFO_FULL);
      if (w_pop) begin
        r_vid_data <= 8'h00;
        if (!w_head_we) begin
          r_rvalid <= 1'b1;
          r_rdata  <= w_head_ok ? r_mem[w_head_addr[AW-1:0]] : 8'h00;
        end else begin
          r_rvalid <= 1'b0;
        end
      end else begin
        r_vid_data <= w_vid_ok ? r_mem[vid_addr[AW-1:0]] : 8'h00;
        r_rvalid   <= 1'b0;
      end
    end
  end

  assign vid_data   = r_vid_data;
  assign cpu_ready  = r_ready;
  assign cpu_rvalid = r_rvalid;
  assign cpu_rdata  = r_rdata;

endmodule

// File: doc/hpu_vram_port.md
HPU_VRAM_PORT -- requirements
Module: hpu_vram_port

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 16384: VRAM size in bytes, byte-addressed.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: CPU request queue entries, power of two.
REQ-003 SHALL have parameter BLANK_FIRST, default 480: first true_line in the CPU access window.
REQ-004 SHALL have parameter BLANK_LAST, default 519: last true_line in the CPU access window, inclusive.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port true_line, input, 10: current raster line from video timing.
REQ-008 SHALL have port vid_addr, input, 16: tile/nametable/attr fetch address, driven every cycle by the tile fetcher.
REQ-009 SHALL have port vid_data, output, 8: read data for vid_addr.
REQ-010 SHALL have port cpu_valid, input, 1: CPU request present.
REQ-011 SHALL have port cpu_ready, output, 1: request accepted when cpu_valid && cpu_ready.
REQ-012 SHALL have port cpu_we, input, 1: 1 = write, 0 = read.
REQ-013 SHALL have port cpu_addr, input, 16: CPU byte address.
REQ-014 SHALL have port cpu_wdata, input, 8: write data.
REQ-015 SHALL have port cpu_rvalid, output, 1: one-cycle pulse; cpu_rdata valid.
REQ-016 SHALL have port cpu_rdata, output, 8: CPU read data.

Function
REQ-017 SHALL hold MEM_BYTES bytes in one single-port synchronous array, one access per cycle.
REQ-018 SHALL define window = (BLANK_FIRST <= true_line <= BLANK_LAST), evaluated each cycle.
REQ-019 SHALL queue accepted CPU requests {we, addr, wdata} in FIFO order; cpu_ready = not full.
REQ-020 SHALL, per cycle, choose a CPU slot if window && FIFO non-empty, else a video slot.
REQ-021 Video slot: SHALL read vid_addr; vid_data SHALL show that byte on the next cycle (1-cycle latency), registered.
REQ-022 CPU slot: SHALL pop the FIFO head and perform its access; vid_data SHALL be 0x00 on the following cycle.
REQ-023 CPU read: cpu_rvalid SHALL pulse high, with cpu_rdata, exactly 1 cycle after the CPU slot; otherwise cpu_rvalid SHALL be 0 and cpu_rdata SHALL hold its last value.
REQ-024 CPU write: SHALL update the byte at the end of the CPU slot; any later read of that address SHALL see the new value.
REQ-025 Out-of-range address (>= MEM_BYTES) on a video slot or a CPU read SHALL return 0x00; an out-of-range write SHALL be dropped, still popped from the FIFO, with no rvalid.
REQ-026 Push and pop in the same cycle SHALL leave occupancy unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 When full, cpu_ready SHALL be 0 and the request SHALL be stalled, not lost; a pop in that cycle SHALL NOT raise cpu_ready combinationally.
REQ-028 A request accepted while window is true SHALL be serviceable no earlier than the cycle after acceptance.
REQ-029 On leaving the window with entries queued, entries SHALL remain queued until the next window; order SHALL be preserved.
REQ-030 cpu_valid with cpu_ready=0 SHALL have no effect; cpu_addr/cpu_we/cpu_wdata SHALL be sampled only on acceptance.

Reset
REQ-031 While reset is 1 at posedge: FIFO SHALL empty; vid_data=0x00, cpu_rdata=0x00, cpu_rvalid=0, cpu_ready=1 from the next cycle.
REQ-032 Reset SHALL discard queued and in-flight requests, with no rvalid after reset; memory contents SHALL be preserved.
REQ-033 Requests presented while reset is 1 SHALL NOT be accepted.

Verification
REQ-034 Write 0xA5 to 0x1800 at true_line=480, then video reads 0x1800 at true_line=0 -> vid_data=0xA5 one cycle after the address.
REQ-035 Queue 4 writes at true_line=100 -> cpu_ready=0 on the 5th request; vid_data unaffected; at line 480 the writes drain in 4 cycles and cpu_ready returns to 1.
REQ-036 At true_line=490, write 0x3C to 0x2700 and then read 0x2700 back-to-back -> cpu_rvalid pulses with cpu_rdata=0x3C; vid_data=0x00 the cycle after each CPU slot.
REQ-037 At true_line=519, queue 3 requests -> one is serviced at line 519, two remain queued through lines 520-524 and are serviced at the next line 480.
REQ-038 Read 0x4000 and video read 0xFFFF -> both return 0x00; a write to 0x4000 leaves 0x0000 unchanged.
REQ-039 Assert reset with 2 queued reads -> no cpu_rvalid afterwards, cpu_ready=1, earlier-written memory contents intact.
